// File: rtl/pc_next_sel_pkg.sv
// rtl/pc_next_sel_pkg.sv - shared state encodings, source codes and reset vector for the next-PC selector
package pc_next_sel_pkg;

  typedef enum logic [1:0] {
    PCS_RUN       = 2'd0,
    PCS_HOLD      = 2'd1,
    PCS_HOLD_PEND = 2'd2
  } pc_state_t;

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_JMP = 2'd1;
  localparam logic [1:0] SRC_BR  = 2'd2;
  localparam logic [1:0] SRC_EXC = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/mux2_n.sv
// rtl/mux2_n.sv - parameterised 2:1 mux, b wins when sel is high
module mux2_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/pc_pend_reg.sv
// rtl/pc_pend_reg.sv - pending redirect target captured while IF is stalled
module pc_pend_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  input  logic             is_exc,
  output logic [WIDTH-1:0] pend_pc,
  output logic             pend_exc,
  output logic             pend_valid
);

  // Overwrite policy is decided by the caller; capture always loads.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pend_pc    <= '0;
      pend_exc   <= 1'b0;
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_pc    <= target;
      pend_exc   <= is_exc;
      pend_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - registered next-PC selector with stall hold and pending redirect
module pc_next_sel
  import pc_next_sel_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic [WIDTH-1:0] exc_vector_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_inc_o,
  output logic             squash_o,
  output logic             misalign_o
);

  pc_state_t        state, state_nx;
  logic [1:0]       src;
  logic             redirect;
  logic [WIDTH-1:0] pc_jmp, pc_br, live_pc, next_pc;
  logic [WIDTH-1:0] pend_pc;
  logic             pend_exc, pend_valid;
  logic             use_live, load, squash_nx, capture, clear;

  assign pc_inc_o = pc_o + WIDTH'(INC);

  always_comb begin
    src = SRC_SEQ;
    if (exc_i)         src = SRC_EXC;
    else if (branch_i) src = SRC_BR;
    else if (jump_i)   src = SRC_JMP;
  end
  assign redirect = (src != SRC_SEQ);

  mux2_n #(.WIDTH(WIDTH)) u_mux_jmp (.a(pc_inc_o), .b(jump_target_i),   .sel(jump_i),   .y(pc_jmp));
  mux2_n #(.WIDTH(WIDTH)) u_mux_br  (.a(pc_jmp),   .b(branch_target_i), .sel(branch_i), .y(pc_br));
  mux2_n #(.WIDTH(WIDTH)) u_mux_exc (.a(pc_br),    .b(exc_vector_i),    .sel(exc_i),    .y(live_pc));

  // A live exception beats a pending branch/jump on release; otherwise pending wins.
  assign use_live = !pend_valid || (exc_i && !pend_exc);
  mux2_n #(.WIDTH(WIDTH)) u_mux_pend (.a(pend_pc), .b(live_pc), .sel(use_live), .y(next_pc));

  pc_pend_reg #(.WIDTH(WIDTH)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .clear     (clear),
    .target    (live_pc),
    .is_exc    (exc_i),
    .pend_pc   (pend_pc),
    .pend_exc  (pend_exc),
    .pend_valid(pend_valid)
  );

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    squash_nx = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    case (state)
      PCS_RUN, PCS_HOLD: begin
        if (!stall_i) begin
          load      = 1'b1;
          squash_nx = redirect;
          state_nx  = PCS_RUN;
        end else if (redirect) begin
          capture  = 1'b1;
          state_nx = PCS_HOLD_PEND;
        end else begin
          state_nx = PCS_HOLD;
        end
      end
      PCS_HOLD_PEND: begin
        if (!stall_i) begin
          load      = 1'b1;
          squash_nx = 1'b1;
          clear     = 1'b1;
          state_nx  = PCS_RUN;
        end else if (exc_i && !pend_exc) begin
          capture = 1'b1;
        end
      end
      default: state_nx = PCS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PCS_RUN;
      pc_o       <= RESET_VECTOR;
      squash_o   <= 1'b0;
      misalign_o <= |RESET_VECTOR[1:0];
    end else begin
      state    <= state_nx;
      squash_o <= squash_nx;
      if (load) begin
        pc_o       <= next_pc;
        misalign_o <= |next_pc[1:0];
      end
    end
  end

endmodule

// File: tb/tb_pc_next_sel.sv
// tb/tb_pc_next_sel.sv - self-checking bench for pc_next_sel against a behavioural model
module tb_pc_next_sel;

  logic        clk = 1'b0;
  logic        rst, stall_i, exc_i, branch_i, jump_i;
  logic [31:0] exc_vector_i, branch_target_i, jump_target_i;
  logic [31:0] pc_o, pc_inc_o;
  logic        squash_o, misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic        m_squash;
  logic        m_pend_valid, m_pend_exc;
  logic [31:0] m_pend_pc;

  always #5 clk = ~clk;

  pc_next_sel dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .exc_i(exc_i), .exc_vector_i(exc_vector_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .pc_o(pc_o), .pc_inc_o(pc_inc_o), .squash_o(squash_o), .misalign_o(misalign_o)
  );

  // Reference: pc is a plain number, pending redirect is an optional slot.
  task automatic model_step();
    logic        req;
    logic [31:0] winner;
    req    = exc_i || branch_i || jump_i;
    winner = exc_i ? exc_vector_i : branch_i ? branch_target_i : jump_target_i;
    if (rst) begin
      m_pc = 32'hBFC0_0000; m_squash = 0; m_pend_valid = 0; m_pend_exc = 0; m_pend_pc = 0;
    end else if (stall_i) begin
      m_squash = 0;
      if (!m_pend_valid && req) begin
        m_pend_valid = 1; m_pend_pc = winner; m_pend_exc = exc_i;
      end else if (m_pend_valid && exc_i && !m_pend_exc) begin
        m_pend_pc = exc_vector_i; m_pend_exc = 1;
      end
    end else if (m_pend_valid) begin
      m_pc = (exc_i && !m_pend_exc) ? exc_vector_i : m_pend_pc;
      m_squash = 1; m_pend_valid = 0; m_pend_exc = 0;
    end else begin
      m_pc = req ? winner : m_pc + 32'd4;
      m_squash = req;
    end
  endtask

  function automatic logic [65:0] model_vec();
    return {m_pc, m_pc + 32'd4, m_squash, m_pc[1:0] != 2'b00};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; exc_i = 0; branch_i = 0; jump_i = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hBFC0_0000; exp_pc[1] = 32'hBFC0_0004; exp_pc[2] = 32'hBFC0_0008;
    rst = 1; idle_inputs();
    exc_vector_i = 0; branch_target_i = 0; jump_target_i = 0;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pc_o !== exp_pc[i] || squash_o !== 1'b0 || misalign_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: pc=%h squash=%b mis=%b, want pc=%h squash=0 mis=0",
                 i, pc_o, squash_o, misalign_o, exp_pc[i]);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_branch();
    branch_i = 1; branch_target_i = 32'h0040_0020;
    tick();
    branch_i = 0;
    n_checks++;
    if (pc_o !== 32'h0040_0020 || squash_o !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_redirect: pc=%h squash=%b, want 00400020 squash=1", pc_o, squash_o);
    end
    tick();
    n_checks++;
    if (pc_o !== 32'h0040_0024 || squash_o !== 1'b0 || pc_inc_o !== 32'h0040_0028) begin
      n_fail++;
      $display("FAIL branch_follow: pc=%h inc=%h squash=%b, want 00400024 00400028 squash=0",
               pc_o, pc_inc_o, squash_o);
    end
  endtask

  task automatic test_priority();
    exc_i = 1; exc_vector_i = 32'h8000_0180;
    branch_i = 1; branch_target_i = 32'h0040_1000;
    jump_i = 1; jump_target_i = 32'h0040_2000;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_o !== 32'h8000_0180 || squash_o !== 1'b1) begin
      n_fail++;
      $display("FAIL priority_exc: pc=%h squash=%b, want 80000180 squash=1", pc_o, squash_o);
    end
    branch_i = 1; jump_i = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_o !== 32'h0040_1000) begin
      n_fail++;
      $display("FAIL priority_branch: pc=%h, want 00401000", pc_o);
    end
    tick();
  endtask

  task automatic test_stall_pending();
    logic [65:0] exp;
    stall_i = 1; jump_i = 1; jump_target_i = 32'h0040_0100;
    tick();
    jump_i = 0; branch_i = 1; branch_target_i = 32'h0040_0200;
    tick();
    branch_i = 0;
    tick();
    exp = model_vec();
    n_checks++;
    if ({pc_o, pc_inc_o, squash_o, misalign_o} !== exp || pc_o !== 32'h0040_1004) begin
      n_fail++;
      $display("FAIL stall_hold: pc=%h squash=%b, want %h squash=0", pc_o, squash_o, exp[65:34]);
    end
    stall_i = 0;
    tick();
    n_checks++;
    if (pc_o !== 32'h0040_0100 || squash_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h squash=%b, want 00400100 squash=1", pc_o, squash_o);
    end
    tick();
    n_checks++;
    if (pc_o !== 32'h0040_0104 || squash_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_dropped: pc=%h squash=%b, want 00400104 squash=0", pc_o, squash_o);
    end
  endtask

  task automatic test_exc_pending();
    stall_i = 1; jump_i = 1; jump_target_i = 32'h0040_0300;
    tick();
    jump_i = 0; exc_i = 1; exc_vector_i = 32'h8000_0180;
    tick();
    exc_i = 0; stall_i = 0;
    tick();
    n_checks++;
    if (pc_o !== 32'h8000_0180 || squash_o !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_overwrites_pend: pc=%h squash=%b, want 80000180 squash=1", pc_o, squash_o);
    end
    stall_i = 1; jump_i = 1; jump_target_i = 32'h0040_0400;
    tick();
    jump_i = 0; rst = 1;
    tick();
    n_checks++;
    if (pc_o !== 32'hBFC0_0000 || squash_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_stall: pc=%h squash=%b, want bfc00000 squash=0", pc_o, squash_o);
    end
    rst = 0; stall_i = 0;
    tick();
    n_checks++;
    if (pc_o !== 32'hBFC0_0004 || squash_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_cleared: pc=%h squash=%b, want bfc00004 squash=0", pc_o, squash_o);
    end
  endtask

  task automatic test_wrap_misalign();
    logic [31:0] hold_pc;
    jump_i = 1; jump_target_i = 32'hFFFF_FFFC;
    tick();
    jump_i = 0;
    tick();
    n_checks++;
    if (pc_o !== 32'h0000_0000 || pc_inc_o !== 32'h0000_0004 || misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: pc=%h inc=%h mis=%b, want 00000000 00000004 mis=0", pc_o, pc_inc_o, misalign_o);
    end
    jump_i = 1; jump_target_i = 32'h0040_0002;
    tick();
    jump_i = 0;
    n_checks++;
    if (pc_o !== 32'h0040_0002 || misalign_o !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_set: pc=%h mis=%b, want 00400002 mis=1", pc_o, misalign_o);
    end
    hold_pc = m_pc;
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      exc_vector_i = $urandom; branch_target_i = $urandom; jump_target_i = $urandom;
      tick();
    end
    n_checks++;
    if (pc_o !== hold_pc || misalign_o !== 1'b1 || squash_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_req: pc=%h mis=%b squash=%b, want %h mis=1 squash=0",
               pc_o, misalign_o, squash_o, hold_pc);
    end
    stall_i = 0;
    tick();
    n_checks++;
    if (pc_o !== 32'h0040_0006 || misalign_o !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_seq: pc=%h mis=%b, want 00400006 mis=1", pc_o, misalign_o);
    end
  endtask

  task automatic test_random();
    logic [65:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 99) < 2);
      stall_i         = ($urandom_range(0, 99) < 40);
      exc_i           = ($urandom_range(0, 99) < 10);
      branch_i        = ($urandom_range(0, 99) < 15);
      jump_i          = ($urandom_range(0, 99) < 15);
      exc_vector_i    = $urandom;
      branch_target_i = $urandom;
      jump_target_i   = $urandom;
      tick();
      exp = model_vec();
      n_checks++;
      if ({pc_o, pc_inc_o, squash_o, misalign_o} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h inc=%h squash=%b mis=%b, want pc=%h inc=%h squash=%b mis=%b",
                 i, pc_o, pc_inc_o, squash_o, misalign_o, exp[65:34], exp[33:2], exp[1], exp[0]);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    exc_vector_i = 0; branch_target_i = 0; jump_target_i = 0;
    @(negedge clk);
    test_reset();
    test_branch();
    test_priority();
    test_stall_pending();
    test_exc_pending();
    test_wrap_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
